// File: rtl/div_seq_pkg.sv
// Shared types and constants for the sequential signed/unsigned divider.
package div_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } div_state_t;

  localparam int DIV_WIDTH = 32;
  localparam int CNT_W     = $clog2(DIV_WIDTH);

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage

// File: rtl/div_cond_neg.sv
// Conditional two's-complement negate: invert and add one through a ripple
// carry when en is high, plain passthrough otherwise.
module div_cond_neg #(
  parameter int WIDTH = 32
) (
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    logic carry;
    logic bitInv;
    y     = '0;
    carry = en;
    for (int i = 0; i < WIDTH; i++) begin
      bitInv = a[i] ^ en;
      y[i]   = bitInv ^ carry;
      carry  = bitInv & carry;
    end
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle restoring divider (DIV, quotient to LO, remainder to HI).
// Define DIV_UNSIGNED_EN to add the signed_op port for unsigned DIVU support.
module div_seq
  import div_seq_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef DIV_UNSIGNED_EN
  input  logic             signed_op,
`endif
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  div_state_t       state_q;
  logic [WIDTH-1:0] dvd_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] rem_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dvdNeg_q;
  logic             dvsNeg_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] remOut_q;
  logic             dbz_q;

  logic             signedOp;
  logic [WIDTH-1:0] dvdMag;
  logic [WIDTH-1:0] dvsMag;
  logic [WIDTH-1:0] quotFix;
  logic [WIDTH-1:0] remFix;
  logic [WIDTH:0]   remShift_d;
  logic [WIDTH:0]   trial_d;

`ifdef DIV_UNSIGNED_EN
  assign signedOp = signed_op;
`else
  assign signedOp = 1'b1;
`endif

  div_cond_neg #(.WIDTH(WIDTH)) uDvdMag  (.en(dvdNeg_q),            .a(dvd_q), .y(dvdMag));
  div_cond_neg #(.WIDTH(WIDTH)) uDvsMag  (.en(dvsNeg_q),            .a(dvs_q), .y(dvsMag));
  div_cond_neg #(.WIDTH(WIDTH)) uQuotFix (.en(dvdNeg_q ^ dvsNeg_q), .a(dvd_q), .y(quotFix));
  div_cond_neg #(.WIDTH(WIDTH)) uRemFix  (.en(dvdNeg_q),            .a(rem_q), .y(remFix));

  // During ITER dvd_q doubles as the dividend shifter and the quotient collector.
  always_comb begin
    remShift_d = {rem_q, dvd_q[WIDTH-1]};
    trial_d    = remShift_d - {1'b0, dvs_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dvd_q    <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      dvdNeg_q <= 1'b0;
      dvsNeg_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      quot_q   <= '0;
      remOut_q <= '0;
      dbz_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            dvd_q    <= dividend;
            dvs_q    <= divisor;
            dvdNeg_q <= dividend[WIDTH-1] & signedOp;
            dvsNeg_q <= divisor[WIDTH-1] & signedOp;
            quot_q   <= '0;
            remOut_q <= '0;
            dbz_q    <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= PREP;
          end
        end
        PREP: begin
          if (dvs_q == '0) begin
            quot_q   <= DIV_ZERO_QUOT;
            remOut_q <= dvd_q;
            dbz_q    <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            dvd_q   <= dvdMag;
            dvs_q   <= dvsMag;
            rem_q   <= '0;
            cnt_q   <= CNT_W'(WIDTH - 1);
            state_q <= ITER;
          end
        end
        ITER: begin
          if (!trial_d[WIDTH]) begin
            rem_q <= trial_d[WIDTH-1:0];
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b1};
          end else begin
            rem_q <= remShift_d[WIDTH-1:0];
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
          end
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_q <= FIX;
          end
        end
        FIX: begin
          quot_q   <= quotFix;
          remOut_q <= remFix;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = remOut_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: signed results, latency, divide
// by zero, ignored starts, mid-operation reset and optional unsigned mode.
module tb_div_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        signedOp;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;
  int latency;
  int busyCycles;

  div_seq uDut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef DIV_UNSIGNED_EN
    .signed_op  (signedOp),
`endif
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Drives start for one sampling edge (E0), then scrambles the operand inputs.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sop);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    signedOp = sop;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
  endtask

  // Counts negedges after E0 until done; latency stays 0 if the budget runs out.
  task automatic waitDone();
    latency    = 0;
    busyCycles = 0;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      if (busy) busyCycles++;
      if (done) begin
        latency = n;
        break;
      end
    end
  endtask

  initial begin
    rst_n    = 1'b0;
    start    = 1'b0;
    signedOp = 1'b1;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", {31'b0, busy}, 32'd0);
    checkOutput("rst_done", {31'b0, done}, 32'd0);
    checkOutput("rst_quot", quotient, 32'd0);
    checkOutput("rst_rem", remainder, 32'd0);
    checkOutput("rst_dbz", {31'b0, div_by_zero}, 32'd0);
    rst_n = 1'b1;

    applyStimulus(32'd100, 32'd7, 1'b1);
    waitDone();
    checkOutput("p100_7_lat", 32'(latency), 32'd35);
    checkOutput("p100_7_busy", 32'(busyCycles), 32'd34);
    checkOutput("p100_7_quot", quotient, 32'd14);
    checkOutput("p100_7_rem", remainder, 32'd2);
    checkOutput("p100_7_dbz", {31'b0, div_by_zero}, 32'd0);
    checkOutput("p100_7_busy_in_done", {31'b0, busy}, 32'd0);

    // Back-to-back: start raised in the done cycle, accepted one edge later.
    dividend = 32'd20;
    divisor  = 32'd3;
    start    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2b_done_pulse", {31'b0, done}, 32'd0);
    checkOutput("b2b_idle", {31'b0, busy}, 32'd0);
    checkOutput("b2b_quot_held", quotient, 32'd14);
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone();
    checkOutput("b2b_lat", 32'(latency), 32'd35);
    checkOutput("b2b_quot", quotient, 32'd6);
    checkOutput("b2b_rem", remainder, 32'd2);

    applyStimulus(32'hFFFF_FF9C, 32'd7, 1'b1);
    waitDone();
    checkOutput("n100_7_quot", quotient, 32'hFFFF_FFF2);
    checkOutput("n100_7_rem", remainder, 32'hFFFF_FFFE);

    applyStimulus(32'd100, 32'hFFFF_FFF9, 1'b1);
    waitDone();
    checkOutput("p100_n7_quot", quotient, 32'hFFFF_FFF2);
    checkOutput("p100_n7_rem", remainder, 32'd2);

    applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    waitDone();
    checkOutput("ovf_quot", quotient, 32'h8000_0000);
    checkOutput("ovf_rem", remainder, 32'd0);
    checkOutput("ovf_dbz", {31'b0, div_by_zero}, 32'd0);

    applyStimulus(32'h8000_0000, 32'd1, 1'b1);
    waitDone();
    checkOutput("min_1_quot", quotient, 32'h8000_0000);
    checkOutput("min_1_rem", remainder, 32'd0);

    applyStimulus(32'd5, 32'd0, 1'b1);
    waitDone();
    checkOutput("dz_lat", 32'(latency), 32'd2);
    checkOutput("dz_flag", {31'b0, div_by_zero}, 32'd1);
    checkOutput("dz_quot", quotient, 32'hFFFF_FFFF);
    checkOutput("dz_rem", remainder, 32'd5);
    repeat (3) @(negedge clk);
    checkOutput("dz_flag_held", {31'b0, div_by_zero}, 32'd1);
    checkOutput("dz_rem_held", remainder, 32'd5);

    applyStimulus(32'd9, 32'd3, 1'b1);
    @(negedge clk);
    checkOutput("dz_clear_prep", {31'b0, div_by_zero}, 32'd0);
    checkOutput("dz_clear_quot", quotient, 32'd0);
    waitDone();
    checkOutput("p9_3_quot", quotient, 32'd3);
    checkOutput("p9_3_rem", remainder, 32'd0);
    checkOutput("p9_3_dbz", {31'b0, div_by_zero}, 32'd0);

    // A start pulse with new operands mid-ITER must be ignored.
    applyStimulus(32'd1000, 32'd10, 1'b1);
    repeat (10) @(negedge clk);
    dividend = 32'd7;
    divisor  = 32'd7;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    waitDone();
    checkOutput("ign_quot", quotient, 32'd100);
    checkOutput("ign_rem", remainder, 32'd0);
    @(negedge clk);
    @(negedge clk);
    checkOutput("ign_no_restart", {31'b0, busy}, 32'd0);

    // Reset dropped at ITER cycle 10 aborts immediately.
    applyStimulus(32'd100, 32'd7, 1'b1);
    repeat (11) @(negedge clk);
    checkOutput("abort_busy_before", {31'b0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", {31'b0, busy}, 32'd0);
    checkOutput("abort_done", {31'b0, done}, 32'd0);
    checkOutput("abort_quot", quotient, 32'd0);
    checkOutput("abort_rem", remainder, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checkOutput("abort_no_done", {31'b0, done}, 32'd0);
    checkOutput("abort_idle", {31'b0, busy}, 32'd0);

    applyStimulus(32'd77, 32'hFFFF_FFFB, 1'b1);
    waitDone();
    checkOutput("fresh_lat", 32'(latency), 32'd35);
    checkOutput("fresh_quot", quotient, 32'hFFFF_FFF1);
    checkOutput("fresh_rem", remainder, 32'd2);

`ifdef DIV_UNSIGNED_EN
    applyStimulus(32'hFFFF_FFFF, 32'd2, 1'b0);
    waitDone();
    checkOutput("divu_quot", quotient, 32'h7FFF_FFFF);
    checkOutput("divu_rem", remainder, 32'd1);

    applyStimulus(32'hFFFF_FFFF, 32'd2, 1'b1);
    waitDone();
    checkOutput("divs_quot", quotient, 32'd0);
    checkOutput("divs_rem", remainder, 32'hFFFF_FFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
